// File: rtl/fpalu_sequencer.sv
// Multi-cycle launch/stall/writeback sequencer for the FP ALU.
// Holds the PC while the FPALU runs, then issues one FP register write and accumulates fflags.
module fpalu_sequencer #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 16,
  parameter int LAT_MISC = 1,
  parameter int CNT_W    = 5
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic [4:0]  iOp,
  input  logic        iAbort,
  input  logic [31:0] iFPResult,
  input  logic [4:0]  iFPFlags,
  input  logic        iClearFlags,
  output logic        oFPStart,
  output logic        oStall,
  output logic        oFPRegWrite,
  output logic [31:0] oWBData,
  output logic        oIllegal,
  output logic        oBusy,
  output logic [4:0]  oFFlags,
  output logic [31:0] oStallCount
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;

  localparam logic [CNT_W-1:0] L_ADD  = CNT_W'(LAT_ADD  - 1);
  localparam logic [CNT_W-1:0] L_MUL  = CNT_W'(LAT_MUL  - 1);
  localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(LAT_DIV  - 1);
  localparam logic [CNT_W-1:0] L_SQRT = CNT_W'(LAT_SQRT - 1);
  localparam logic [CNT_W-1:0] L_MISC = CNT_W'(LAT_MISC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, lat;
  logic [4:0]       pend;
  logic             fp_start, stall, reg_write, illegal;

  // Latency is fixed by the counter load at launch, so later iOp changes cannot stretch WAIT.
  always_comb begin
    case (iOp[3:0])
      4'd0, 4'd1: lat = L_ADD;
      4'd2:       lat = L_MUL;
      4'd3:       lat = L_DIV;
      4'd4:       lat = L_SQRT;
      default:    lat = L_MISC;
    endcase
  end

  always_comb begin
    state_nxt = state;
    fp_start  = 1'b0;
    stall     = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IDLE: if (iStart) begin
        if (!iOp[4]) begin
          fp_start  = 1'b1;
          stall     = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          illegal = 1'b1;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (iAbort)          state_nxt = S_IDLE;
        else if (cnt == '0)  state_nxt = S_WB;
      end
      S_WB: begin
        reg_write = !iAbort;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Combinational strobes are masked while reset is held so every output reads 0.
  assign oFPStart    = fp_start  & ~iRST;
  assign oStall      = stall     & ~iRST;
  assign oFPRegWrite = reg_write & ~iRST;
  assign oIllegal    = illegal   & ~iRST;
  assign oBusy       = (state != S_IDLE);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pend        <= '0;
      oWBData     <= '0;
      oFFlags     <= '0;
      oStallCount <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (fp_start) begin
          cnt  <= lat;
          pend <= '0;
        end
        S_WAIT: if (!iAbort) begin
          if (cnt == '0) begin
            oWBData <= iFPResult;
            pend    <= pend | iFPFlags;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
      // Clear first, then OR, so flags from a coincident writeback survive.
      if (state == S_WB && !iAbort) oFFlags <= (iClearFlags ? 5'd0 : oFFlags) | pend;
      else if (iClearFlags)         oFFlags <= '0;
      if (stall && oStallCount != 32'hFFFF_FFFF) oStallCount <= oStallCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_fpalu_sequencer.sv
// Directed bench for fpalu_sequencer: launch/stall/writeback timing, flags, abort, reset.
module tb_fpalu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, clear_flags;
  logic [4:0]  op, flags;
  logic [31:0] result;
  logic        fp_start, stall, reg_write, illegal, busy;
  logic [31:0] wb_data, stall_count;
  logic [4:0]  fflags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpalu_sequencer dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .iOp(op), .iAbort(abort),
    .iFPResult(result), .iFPFlags(flags), .iClearFlags(clear_flags),
    .oFPStart(fp_start), .oStall(stall), .oFPRegWrite(reg_write), .oWBData(wb_data),
    .oIllegal(illegal), .oBusy(busy), .oFFlags(fflags), .oStallCount(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs changed afterwards belong to the new cycle.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; clear_flags = 1'b0;
    op = '0; flags = '0; result = '0;
    #3;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb", wb_data, 32'd0);
    chk("rst_cnt", stall_count, 32'd0);
    tick(); rst = 1'b0;
    tick();

    // FADD: launch cycle 0, WAIT 1-3, WB 4
    start = 1'b1; op = 5'd0; result = 32'h4040_0000; flags = 5'd0; settle();
    chk("fadd_start", {31'd0, fp_start}, 32'd1);
    chk("fadd_stall0", {31'd0, stall}, 32'd1);
    tick(); start = 1'b0; settle();
    chk("fadd_nostart1", {31'd0, fp_start}, 32'd0);
    chk("fadd_busy1", {31'd0, busy}, 32'd1);
    tick(); tick(); settle();
    chk("fadd_stall3", {31'd0, stall}, 32'd1);
    chk("fadd_nowr3", {31'd0, reg_write}, 32'd0);
    tick(); settle();
    chk("fadd_wr4", {31'd0, reg_write}, 32'd1);
    chk("fadd_wb4", wb_data, 32'h4040_0000);
    chk("fadd_nostall4", {31'd0, stall}, 32'd0);
    tick(); settle();
    chk("fadd_idle5", {31'd0, busy}, 32'd0);
    chk("fadd_stallcnt", stall_count, 32'd4);

    // FDIV then FSQRT back to back
    start = 1'b1; op = 5'd3; result = 32'h3F80_0000; flags = 5'b01000; settle();
    chk("fdiv_start", {31'd0, fp_start}, 32'd1);
    tick(); start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    settle();
    chk("fdiv_nowr12", {31'd0, reg_write}, 32'd0);
    tick(); settle();
    chk("fdiv_wr13", {31'd0, reg_write}, 32'd1);
    chk("fdiv_wb13", wb_data, 32'h3F80_0000);
    tick();
    start = 1'b1; op = 5'd4; result = 32'h4000_0000; flags = 5'd0; settle();
    chk("fdiv_fflags", {27'd0, fflags}, 32'h08);
    chk("fsqrt_start14", {31'd0, fp_start}, 32'd1);
    tick(); start = 1'b0; op = 5'd0;  // latency must stay frozen
    for (int i = 0; i < 15; i++) tick();
    settle();
    chk("fsqrt_nowr30", {31'd0, reg_write}, 32'd0);
    chk("fsqrt_stall30", {31'd0, stall}, 32'd1);
    tick(); settle();
    chk("fsqrt_wr31", {31'd0, reg_write}, 32'd1);
    chk("fsqrt_wb31", wb_data, 32'h4000_0000);
    tick(); settle();
    chk("fsqrt_fflags", {27'd0, fflags}, 32'h08);
    chk("b2b_stallcnt", stall_count, 32'd34);

    // Illegal op
    start = 1'b1; op = 5'd20; settle();
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_stall", {31'd0, stall}, 32'd0);
    chk("ill_nostart", {31'd0, fp_start}, 32'd0);
    tick(); start = 1'b0; settle();
    chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
    chk("ill_busy", {31'd0, busy}, 32'd0);

    // FMUL aborted in its 2nd WAIT cycle
    start = 1'b1; op = 5'd2; result = 32'hDEAD_BEEF; flags = 5'b00100;
    tick(); start = 1'b0;
    tick(); abort = 1'b1; settle();
    chk("abort_nowr", {31'd0, reg_write}, 32'd0);
    tick(); abort = 1'b0; settle();
    chk("abort_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_never_wr", {31'd0, reg_write}, 32'd0);
      tick(); settle();
    end
    chk("abort_fflags", {27'd0, fflags}, 32'h08);
    chk("abort_wbhold", wb_data, 32'h4000_0000);
    chk("abort_stallcnt", stall_count, 32'd37);

    // Clear, set 00001, then clear coincident with WB carrying 10000
    clear_flags = 1'b1; tick(); clear_flags = 1'b0; settle();
    chk("clr_fflags", {27'd0, fflags}, 32'd0);
    start = 1'b1; op = 5'd7; flags = 5'b00001; result = 32'h1111_1111;
    tick(); start = 1'b0; tick(); tick(); settle();
    chk("nx_fflags", {27'd0, fflags}, 32'h01);
    start = 1'b1; op = 5'd9; flags = 5'b10000; result = 32'h2222_2222;
    tick(); start = 1'b0; tick(); clear_flags = 1'b1; settle();
    chk("clrwb_wr", {31'd0, reg_write}, 32'd1);
    tick(); clear_flags = 1'b0; settle();
    chk("clrwb_fflags", {27'd0, fflags}, 32'h10);

    // Reset mid-WAIT of FDIV, then FMIN
    start = 1'b1; op = 5'd3; flags = 5'b00010;
    tick(); start = 1'b0; tick(); tick();
    rst = 1'b1; settle();
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_stall", {31'd0, stall}, 32'd0);
    chk("mrst_fflags", {27'd0, fflags}, 32'd0);
    chk("mrst_wb", wb_data, 32'd0);
    chk("mrst_cnt", stall_count, 32'd0);
    tick(); rst = 1'b0;
    start = 1'b1; op = 5'd5; flags = 5'd0; result = 32'h1234_5678; settle();
    chk("fmin_start", {31'd0, fp_start}, 32'd1);
    tick(); start = 1'b0; settle();
    chk("fmin_wait", {31'd0, stall}, 32'd1);
    tick(); settle();
    chk("fmin_wr", {31'd0, reg_write}, 32'd1);
    chk("fmin_wb", wb_data, 32'h1234_5678);
    tick(); settle();
    chk("fmin_done", {31'd0, busy}, 32'd0);
    chk("fmin_fflags", {27'd0, fflags}, 32'd0);
    chk("fmin_stallcnt", stall_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
